axi_line_master: RTL



---
 rtl/axi_line_master_if.sv | 85 ++++++++
 rtl/axi_line_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axi_line_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_line_master_if
// Desc     : Cache request/response channel plus AXI4 AR/R/AW/W/B channels
//            bundled for axi_line_master. The master modport is the block's
//            view; the slave modport is the cache + memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_line_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
);
   localparam int c_LINE_W = BEATS * DATA_W;

   // cache request / response
   logic                req_valid;
   logic                req_ready;
   logic                req_wr;
   logic [ADDR_W-1:0]   req_addr;
   logic [c_LINE_W-1:0] req_wline;
   logic                resp_valid;
   logic [c_LINE_W-1:0] resp_rline;
   logic                resp_err;

   // read address / data
   logic [ADDR_W-1:0]   araddr;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   // write address / data / response
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [63:0]         wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      input  req_valid, req_wr, req_addr, req_wline,
      output req_ready, resp_valid, resp_rline, resp_err,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready,
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wline,
      input  req_ready, resp_valid, resp_rline, resp_err,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready,
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface
`default_nettype wire

// File: rtl/axi_line_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_line_master
// Desc     : Turns one cache-line refill or writeback into a single AXI INCR
//            burst and returns the assembled line. One transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module axi_line_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
) (
   input  logic             clk,
   input  logic             rst,
   axi_line_master_if.master bus
);
   localparam int c_LINE_W = BEATS * DATA_W;
   localparam int c_CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int c_OFF_W  = $clog2(c_LINE_W / 8);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0]  c_ALIGN = ~((ADDR_W'(1) << c_OFF_W) - ADDR_W'(1));

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_WR   = 3'd3,
      S_B    = 3'd4,
      S_RESP = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [c_LINE_W-1:0] r_wline;
   logic [c_LINE_W-1:0] r_rline;
   logic [c_LINE_W-1:0] r_out_line;
   logic                r_out_err;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_full;
   logic                r_aw_done;
   logic                r_w_done;
   logic                r_err;
   logic                w_run;
   logic                w_aw_fin;
   logic                w_w_fin;

   // Reset forces every handshake output low immediately, not one edge later.
   assign w_run    = ~rst;
   assign w_aw_fin = r_aw_done | bus.awready;
   assign w_w_fin  = r_w_done | (bus.wready && (r_cnt == c_LAST));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode; AW and W may finish in either order or together.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.req_valid) w_next = bus.req_wr ? S_WR : S_AR;
         S_AR:   if (bus.arready) w_next = S_R;
         S_R:    if (bus.rvalid && bus.rlast) w_next = S_RESP;
         S_WR:   if (w_aw_fin && w_w_fin) w_next = S_B;
         S_B:    if (bus.bvalid) w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Burst counter, line assembly, done flags and error accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_wline    <= '0;
         r_rline    <= '0;
         r_out_line <= '0;
         r_out_err  <= 1'b0;
         r_cnt      <= '0;
         r_full     <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_addr    <= bus.req_addr & c_ALIGN;
                  r_wline   <= bus.req_wline;
                  r_cnt     <= '0;
                  r_full    <= 1'b0;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_err     <= 1'b0;
               end
            end
            S_R: begin
               if (bus.rvalid) begin
                  if (bus.rresp != 2'b00) r_err <= 1'b1;
                  // once the last slot is filled, further beats are dropped
                  if (r_full) begin
                     r_err <= 1'b1;
                  end else begin
                     r_rline[r_cnt*DATA_W +: DATA_W] <= bus.rdata;
                     if (r_cnt == c_LAST) r_full <= 1'b1;
                     else                 r_cnt  <= r_cnt + c_CNT_W'(1);
                  end
                  if (bus.rlast && (r_cnt != c_LAST)) r_err <= 1'b1;
               end
            end
            S_WR: begin
               if (bus.awready && !r_aw_done) r_aw_done <= 1'b1;
               if (bus.wready && !r_w_done) begin
                  if (r_cnt == c_LAST) r_w_done <= 1'b1;
                  else                 r_cnt    <= r_cnt + c_CNT_W'(1);
               end
            end
            S_B: begin
               if (bus.bvalid && (bus.bresp != 2'b00)) r_err <= 1'b1;
            end
            S_RESP: begin
               r_out_line <= r_rline;
               r_out_err  <= r_err;
            end
            default: ;
         endcase
      end
   end

   // Cache-side outputs; the response is shadowed so it holds between RESPs.
   assign bus.req_ready  = w_run && (r_state == S_IDLE);
   assign bus.resp_valid = w_run && (r_state == S_RESP);
   assign bus.resp_rline = !w_run ? '0 : ((r_state == S_RESP) ? r_rline : r_out_line);
   assign bus.resp_err   = w_run && ((r_state == S_RESP) ? r_err : r_out_err);

   // AXI read channel outputs.
   assign bus.araddr  = r_addr;
   assign bus.arlen   = 4'(BEATS - 1);
   assign bus.arsize  = 3'b011;
   assign bus.arburst = 2'b01;
   assign bus.arvalid = w_run && (r_state == S_AR);
   assign bus.rready  = w_run && (r_state == S_R);

   // AXI write channel outputs.
   assign bus.awaddr  = r_addr;
   assign bus.awlen   = 4'(BEATS - 1);
   assign bus.awsize  = 3'b011;
   assign bus.awburst = 2'b01;
   assign bus.awvalid = w_run && (r_state == S_WR) && !r_aw_done;
   assign bus.wdata   = r_wline[r_cnt*DATA_W +: DATA_W];
   assign bus.wstrb   = '1;
   assign bus.wlast   = (r_cnt == c_LAST);
   assign bus.wvalid  = w_run && (r_state == S_WR) && !r_w_done;
   assign bus.bready  = w_run && (r_state == S_B);

endmodule
`default_nettype wire
